multiword_add_sequencer: RTL and testbench
==========================================

MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 Parameter WORDS, default 4, number of 8-bit limbs per operand (legal range 1..16).
REQ-002 clk  input  1  single clock, all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand request.
REQ-005 in_ready  output  1  block can accept an operand pair this cycle.
REQ-006 op_a  input  8*WORDS  first operand, unsigned or two's-complement.
REQ-007 op_b  input  8*WORDS  second operand.
REQ-008 sub  input  1  0 selects op_a+op_b, 1 selects op_a-op_b; sampled with the operands.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  8*WORDS  sum or difference, modulo 2^(8*WORDS).
REQ-012 carry_out  output  1  carry out of the top limb; for sub, 1 means no borrow.
REQ-013 overflow  output  1  signed two's-complement overflow of the operation.

Function
REQ-014 The block SHALL compute the full-width result with one 8-bit ripple carry adder, processing one limb per clock, least-significant limb first.
REQ-015 FSM states SHALL be IDLE, RUN, and DONE.
REQ-016 In IDLE, in_valid && in_ready at an edge SHALL register op_a, op_b and sub, clear the limb index, load the carry register with sub, and enter RUN.
REQ-017 In RUN, limb i SHALL be formed as op_a[i] + (sub ? ~op_b[i] : op_b[i]) + carry; the sum SHALL be written to result[8i+7:8i] and the adder cout SHALL go to the carry register.
REQ-018 In RUN, the limb index SHALL increment each cycle; after limb WORDS-1 is written, the FSM SHALL enter DONE.
REQ-019 For WORDS=1, RUN SHALL last exactly one cycle.
REQ-020 Latency: with acceptance at edge k, out_valid SHALL be high from the cycle after edge k+WORDS.
REQ-021 carry_out SHALL equal the final carry register value.
REQ-022 overflow SHALL be 1 when the top bit of op_a equals the top bit of the effective op_b (inverted when sub=1) and differs from the top bit of result; it SHALL be captured when entering DONE.
REQ-023 In DONE, out_valid SHALL be 1; result, carry_out and overflow SHALL hold stable until out_valid && out_ready.
REQ-024 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready is 1, and 0 otherwise, including the whole of RUN.
REQ-025 In DONE with out_ready=1 and in_valid=1, the result SHALL retire and the new operands SHALL be accepted on the same edge, going directly to RUN with no bubble.
REQ-026 In DONE with out_ready=1 and in_valid=0, the FSM SHALL enter IDLE and out_valid SHALL fall.
REQ-027 in_valid asserted during RUN SHALL be ignored; the operands SHALL not be sampled.
REQ-028 Changes to op_a, op_b or sub after acceptance SHALL not affect the operation in flight.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, limb index 0, carry register 0, result 0, carry_out 0, overflow 0, and out_valid 0.
REQ-030 Reset during RUN or DONE SHALL abort the operation and discard its result; in_ready SHALL be 1 in the first cycle after rst_n rises.

Structure
REQ-031 The FSM state encoding and LIMB_W=8 SHALL live in the shared adder_seq_pkg package and header.
REQ-032 The block SHALL instantiate exactly one ripple_carry_adder_8 as its sole arithmetic sub-module, with no other adders in the datapath.

Verification (WORDS=4)
REQ-033 0x000000FF + 0x00000001, sub=0 -> result 0x00000100, carry_out 0, overflow 0, out_valid in the 5th cycle after acceptance.
REQ-034 0xFFFFFFFF + 0x00000001 -> result 0x00000000, carry_out 1, overflow 0.
REQ-035 0x7FFFFFFF + 0x00000001 -> result 0x80000000, carry_out 0, overflow 1.
REQ-036 0x00000005 - 0x00000007, sub=1 -> result 0xFFFFFFFE, carry_out 0, overflow 0.
REQ-037 out_ready held low 3 cycles in DONE -> outputs stable and in_ready=0; then out_ready=1 with a new in_valid -> accepted on the same edge, with the next out_valid 4 cycles later.
REQ-038 rst_n pulsed low during RUN on limb 2 -> out_valid=0, result=0 immediately; after release in_ready=1 and a fresh add completes correctly.

Source files
------------

// File: rtl/adder_seq_pkg.sv
// Shared definitions for the multiword add/subtract sequencer: limb width
// and the controller state encoding.
package adder_seq_pkg;

   localparam int LIMB_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

endpackage

// File: rtl/ripple_carry_adder_8.sv
// Single limb-wide ripple carry adder; the only arithmetic element of the
// sequencer datapath.
module ripple_carry_adder_8
   import adder_seq_pkg::*;
(
   input  logic [LIMB_W-1:0] a,
   input  logic [LIMB_W-1:0] b,
   input  logic              cin,
   output logic [LIMB_W-1:0] sum,
   output logic              cout
);

   always_comb begin
      logic cy;
      cy  = cin;
      sum = '0;
      for (int i = 0; i < LIMB_W; i++) begin
         sum[i] = a[i] ^ b[i] ^ cy;
         cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
      end
      cout = cy;
   end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multiword add/subtract: one 8-bit limb per clock through a single ripple
// adder, LSB limb first, with a valid/ready handshake on both sides.
//
// state   | meaning
// ST_IDLE | waiting for an operand pair, in_ready high
// ST_RUN  | processing limb idx_q, one limb per cycle
// ST_DONE | result held with out_valid high until the consumer takes it
module multiword_add_sequencer
   import adder_seq_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LIMB_W*WORDS-1:0] op_a,
   input  logic [LIMB_W*WORDS-1:0] op_b,
   input  logic                  sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LIMB_W*WORDS-1:0] result,
   output logic                  carry_out,
   output logic                  overflow
);

   localparam int W     = LIMB_W * WORDS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   seq_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             sub_q, sub_d;
   logic [W-1:0]     result_q, result_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;

   logic [LIMB_W-1:0] limb_a, limb_b, limb_b_eff, limb_sum;
   logic              limb_cout;
   logic              fire_out, accept;

   always_comb begin
      limb_a = '0;
      limb_b = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            limb_a = a_q[i*LIMB_W +: LIMB_W];
            limb_b = b_q[i*LIMB_W +: LIMB_W];
         end
      end
      limb_b_eff = sub_q ? ~limb_b : limb_b;
   end

   ripple_carry_adder_8 u_rca (
      .a    (limb_a),
      .b    (limb_b_eff),
      .cin  (carry_q),
      .sum  (limb_sum),
      .cout (limb_cout)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      sub_d       = sub_q;
      result_d    = result_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;

      fire_out = (state_q == ST_DONE) && out_ready;
      in_ready = (state_q == ST_IDLE) || fire_out;
      accept   = in_valid && in_ready;

      case (state_q)
         ST_RUN: begin
            for (int i = 0; i < WORDS; i++) begin
               if (idx_q == IDX_W'(i)) result_d[i*LIMB_W +: LIMB_W] = limb_sum;
            end
            carry_d = limb_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d       = '0;
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
               // signed overflow: like-signed operands giving an opposite-signed result
               ovf_d = (limb_a[LIMB_W-1] == limb_b_eff[LIMB_W-1]) &&
                       (limb_sum[LIMB_W-1] != limb_a[LIMB_W-1]);
            end
         end
         ST_DONE: begin
            if (fire_out) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: ;
      endcase

      // a DONE-state handoff retires the old result and starts the new one on the same edge
      if (accept) begin
         a_d         = op_a;
         b_d         = op_b;
         sub_d       = sub;
         idx_d       = '0;
         carry_d     = sub;
         state_d     = ST_RUN;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sub_q       <= 1'b0;
         result_q    <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sub_q       <= sub_d;
         result_q    <= result_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign carry_out = carry_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer (WORDS=4): transaction-level model plus
// directed corner cases and a randomized handshake phase.
module tb_multiword_add_sequencer;

   localparam int WORDS = 4;
   localparam int W     = 8 * WORDS;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         sub = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         in_ready, out_valid, carry_out, overflow;
   logic [W-1:0] result;

   multiword_add_sequencer #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] res;
      logic        c;
      logic        o;
   } exp_t;

   exp_t exp_q[$];
   int   rem = -1;     // -1 idle, >0 cycles of work left, 0 result presented
   logic m_fire, m_acc;

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
      exp_t        e;
      logic [32:0] full;
      longint      sa, sb, sr;
      if (s) begin
         e.res = a - b;
         e.c   = (a >= b);
      end else begin
         full  = {1'b0, a} + {1'b0, b};
         e.res = full[31:0];
         e.c   = full[32];
      end
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      sr  = s ? (sa - sb) : (sa + sb);
      e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem = -1;
         exp_q.delete();
      end else begin
         m_fire = (rem == 0) && out_ready;
         m_acc  = in_valid && ((rem < 0) || m_fire);
         if (m_fire) void'(exp_q.pop_front());
         if (rem > 0) rem--;
         if (m_fire && !m_acc) rem = -1;
         if (m_acc) begin
            exp_q.push_back(model(op_a, op_b, sub));
            rem = WORDS;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("out_valid", 64'(out_valid), 64'(rem == 0));
         check("in_ready", 64'(in_ready), 64'((rem < 0) || (rem == 0 && out_ready)));
         if (rem == 0 && exp_q.size() > 0) begin
            check("result", 64'(result), 64'(exp_q[0].res));
            check("carry_out", 64'(carry_out), 64'(exp_q[0].c));
            check("overflow", 64'(overflow), 64'(exp_q[0].o));
         end
      end
   end

   task automatic wait_valid(output int n);
      n = 1;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] er, input logic ec, input logic eo, input string tag);
      int n;
      @(posedge clk); #1;
      in_valid = 1'b1; op_a = a; op_b = b; sub = s; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; op_a = $urandom; op_b = $urandom; sub = $urandom_range(0, 1);
      wait_valid(n);
      check({tag, "_latency"}, 64'(n), 64'd5);
      check({tag, "_result"}, 64'(result), 64'(er));
      check({tag, "_carry"}, 64'(carry_out), 64'(ec));
      check({tag, "_ovf"}, 64'(overflow), 64'(eo));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      int          n;
      logic [31:0] held;

      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_carry", 64'(carry_out), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("model_pin_add", 64'(model(32'h7FFF_FFFF, 32'h1, 1'b0)), {30'd0, 32'h8000_0000, 1'b0, 1'b1});
      check("model_pin_sub", 64'(model(32'h5, 32'h7, 1'b1)), {30'd0, 32'hFFFF_FFFE, 1'b0, 1'b0});
      @(posedge clk); #1;
      rst_n = 1'b1;

      do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "add_ff_1");
      do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add_wrap");
      do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
      do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
      do_op(32'h0000_0009, 32'h0000_0003, 1'b1, 32'h0000_0006, 1'b1, 1'b0, "sub_noborrow");

      // backpressure in DONE, then back-to-back handoff
      @(posedge clk); #1;
      in_valid = 1'b1; op_a = 32'h1234_5678; op_b = 32'h1111_1111; sub = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1; op_a = 32'hDEAD_BEEF; op_b = 32'h0000_0001;
      wait_valid(n);
      in_valid = 1'b0;
      check("bp_result", 64'(result), 64'h2345_6789);
      held = result;
      for (int i = 0; i < 3; i++) begin
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_stable", 64'(result), 64'(held));
         check("bp_valid", 64'(out_valid), 64'd1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1; in_valid = 1'b1;
      op_a = 32'h8000_0000; op_b = 32'h0000_0001; sub = 1'b1;
      #1;
      check("handoff_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0; op_a = $urandom; op_b = $urandom;
      check("handoff_no_valid", 64'(out_valid), 64'd0);
      wait_valid(n);
      check("handoff_latency", 64'(n), 64'd5);
      check("handoff_result", 64'(result), 64'h7FFF_FFFF);
      check("handoff_carry", 64'(carry_out), 64'd1);
      check("handoff_ovf", 64'(overflow), 64'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // reset while limb 2 is in progress
      @(posedge clk); #1;
      in_valid = 1'b1; op_a = 32'h0102_0304; op_b = 32'h1010_1010; sub = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_result", 64'(result), 64'd0);
      check("abort_carry", 64'(carry_out), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("abort_in_ready", 64'(in_ready), 64'd1);
      do_op(32'h0102_0304, 32'h1010_1010, 1'b0, 32'h1112_1314, 1'b0, 1'b0, "post_reset");

      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 3) != 0);
         op_a      = pick();
         op_b      = pick();
         sub       = ($urandom_range(0, 1) == 1);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("drain_idle", 64'(out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
